// File: rtl/channel_send.sv
// channel_send: transmitter side of the channel rendezvous, driving the shared single-port RAM
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 8
`endif
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module channel_send #(
    parameter int addrBits = `ADDRESS_BITS,
    parameter int dataBits = `DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [addrBits-1:0] channel,
    input  logic [addrBits-1:0] txPid,
    input  logic [dataBits-1:0] message,
    output logic [addrBits-1:0] address,
    output logic                readWriteMode,
    output logic [dataBits-1:0] dataIn,
    input  logic [dataBits-1:0] dataOut,
    output logic                finished,
    output logic                txMustWait,
    output logic                wakeValid,
    output logic [addrBits-1:0] wakePid,
    output logic                protocolError
);

    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE_MSG, WRITE_CHAN, DONE} state_t;

    state_t              state_q, state_d;
    logic [addrBits-1:0] chan_q, chan_d, pid_q, pid_d, word_q, word_d, wake_pid_q, wake_pid_d;
    logic [dataBits-1:0] msg_q, msg_d;
    logic                must_wait_q, must_wait_d, wake_valid_q, wake_valid_d, perr_q, perr_d;

    // state register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next-state: a self-addressed channel word skips both writes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       state_d = start ? READ : IDLE;
            READ:       state_d = CHECK;
            CHECK:      state_d = (dataOut[addrBits-1:0] == pid_q) ? DONE : WRITE_MSG;
            WRITE_MSG:  state_d = WRITE_CHAN;
            WRITE_CHAN: state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // RAM bus and strobe decode, zero outside the states that use them
    always_comb begin
        address       = '0;
        readWriteMode = 1'b0;
        dataIn        = '0;
        case (state_q)
            READ:       address = chan_q;
            WRITE_MSG: begin
                address       = chan_q + addrBits'(1);
                readWriteMode = 1'b1;
                dataIn        = msg_q;
            end
            WRITE_CHAN: begin
                address       = chan_q;
                readWriteMode = 1'b1;
                dataIn        = (word_q == '0) ? dataBits'(pid_q) : '0;
            end
            default: ;
        endcase
        finished = (state_q == DONE);
    end

    // request latches and result flags; flags persist until the next accepted start
    always_comb begin
        chan_d       = chan_q;
        pid_d        = pid_q;
        msg_d        = msg_q;
        word_d       = word_q;
        must_wait_d  = must_wait_q;
        wake_valid_d = wake_valid_q;
        wake_pid_d   = wake_pid_q;
        perr_d       = perr_q;
        if (state_q == IDLE && start) begin
            chan_d       = channel;
            pid_d        = txPid;
            msg_d        = message;
            must_wait_d  = 1'b0;
            wake_valid_d = 1'b0;
            perr_d       = 1'b0;
        end
        if (state_q == CHECK) begin
            word_d = dataOut[addrBits-1:0];
            perr_d = (dataOut[addrBits-1:0] == pid_q);
        end
        if (state_q == WRITE_CHAN) begin
            must_wait_d  = (word_q == '0);
            wake_valid_d = (word_q != '0);
            wake_pid_d   = (word_q != '0) ? word_q : wake_pid_q;
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chan_q       <= '0;
            pid_q        <= '0;
            msg_q        <= '0;
            word_q       <= '0;
            must_wait_q  <= 1'b0;
            wake_valid_q <= 1'b0;
            wake_pid_q   <= '0;
            perr_q       <= 1'b0;
        end else begin
            chan_q       <= chan_d;
            pid_q        <= pid_d;
            msg_q        <= msg_d;
            word_q       <= word_d;
            must_wait_q  <= must_wait_d;
            wake_valid_q <= wake_valid_d;
            wake_pid_q   <= wake_pid_d;
            perr_q       <= perr_d;
        end
    end

    assign txMustWait    = must_wait_q;
    assign wakeValid     = wake_valid_q;
    assign wakePid       = wake_pid_q;
    assign protocolError = perr_q;

endmodule

// File: doc/channel_send.md
Name: channel_send

Overview:
- Transmitter end of the channel rendezvous protocol. The receive-side enable block records a waiting receiver pid in a channel word; this block performs the matching send.
- On each `start` pulse it reads the channel word in shared RAM and then takes one of two paths:
  - Receiver waiting: deposit the message, clear the channel and report the receiver pid to wake.
  - Channel empty: deposit the message, park the sender pid in the channel and report that the sender must block.
- It sits between the process scheduler and the single-port IceRam. It is the sole RAM master while busy.

Parameters:
- addrBits, default `ADDRESS_BITS`: RAM address width, also the pid width.
- dataBits, default `DATA_BITS`: RAM word width; must be >= addrBits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- channel  input  addrBits  address of the channel word; the message slot is channel+1.
- txPid  input  addrBits  pid of the sending process; must be nonzero.
- message  input  dataBits  value to transmit.
- address  output  addrBits  RAM address.
- readWriteMode  output  1  1 = write, 0 = read.
- dataIn  output  dataBits  RAM write data.
- dataOut  input  dataBits  RAM read data; valid one cycle after the address is presented.
- finished  output  1  one-cycle completion strobe.
- txMustWait  output  1  1 = no receiver was waiting; the sender is parked.
- wakeValid  output  1  1 = a receiver pid is presented on wakePid.
- wakePid  output  addrBits  pid of the receiver to make runnable.
- protocolError  output  1  the channel word already held txPid.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - address, dataIn, readWriteMode, finished, txMustWait, wakeValid, wakePid and protocolError all go to 0.
  - Internal latches are cleared.
- Channel word encoding: 0 = empty; nonzero = pid of the waiting receiver.
- State sequence, one state per cycle: IDLE -> READ -> CHECK -> WRITE_MSG -> WRITE_CHAN -> DONE -> IDLE.
- IDLE:
  - readWriteMode = 0.
  - On a rising edge with start=1: latch channel, txPid and message; clear txMustWait, wakeValid and protocolError; go to READ.
- READ: address = latched channel, readWriteMode = 0.
- CHECK:
  - Capture word = dataOut[addrBits-1:0].
  - word == latched txPid: set protocolError; go straight to DONE with no writes; RAM is left untouched.
- WRITE_MSG: address = channel+1, computed modulo 2^addrBits; dataIn = message; readWriteMode = 1.
- WRITE_CHAN: address = channel, readWriteMode = 1.
  - word == 0: dataIn = zero-extended txPid; set txMustWait.
  - word != 0: dataIn = 0; wakePid = word; set wakeValid.
- DONE:
  - readWriteMode = 0; finished = 1 for exactly this cycle.
  - txMustWait, wakeValid, wakePid and protocolError hold their values until the next accepted start.
- Latency: finished is high in the 5th cycle after the edge that sampled start, or the 3rd cycle on protocolError.
- readWriteMode is 1 only in WRITE_MSG and WRITE_CHAN.
- start while not in IDLE is ignored and not queued. A start coincident with DONE is also ignored.
- Inputs channel, txPid and message may change after start is accepted; only the latched copies are used.
- channel = all-ones: the message slot wraps to address 0.
- Reset mid-operation: aborts immediately and no further writes occur. A message written in WRITE_MSG without the following channel update is permitted; the scheduler must re-issue the send.
- Receiver side contract: on wake, the receiver reads the message at channel+1 and finds the channel word already 0.

Test Plan:
- Empty channel: ram[2]=0, channel=2, txPid=1, message=16'hBEEF, pulse start.
  - Expect finished 5 cycles later with txMustWait=1, wakeValid=0.
  - Expect ram[2]=1 and ram[3]=16'hBEEF.
- Receiver waiting: ram[2]=3, txPid=1, message=16'h0042, pulse start.
  - Expect txMustWait=0, wakeValid=1, wakePid=3.
  - Expect ram[2]=0 and ram[3]=16'h0042.
- Self-collision: ram[2]=1, txPid=1, pulse start.
  - Expect finished 3 cycles later with protocolError=1.
  - Expect ram[2] and ram[3] unchanged, and readWriteMode never 1.
- Wrap and busy-start: channel = all-ones with ram[all-ones]=0; pulse start, then pulse start again 2 cycles later.
  - Expect the message at ram[0] and exactly one finished strobe.
- Reset mid-op: assert reset=0 during WRITE_MSG.
  - Expect all outputs 0 asynchronously and ram[channel] unchanged.
  - After release, a new send completes normally.
- Back-to-back with enable: receiver enable on channel 2 (pid 3) writes ram[2]=3; then send from pid 1.
  - Expect wakePid=3 and ram[2]=0.
